// File: rtl/word_memory_array.sv
// word_memory_array: synchronous WIDTH x DEPTH word store with one addressed
// read/write port, a registered read path with a valid strobe, and a
// sequenced bulk-clear sweep that reports busy while it runs.
//
// Optional feature macro: PARITY_EN. When it is defined, each word carries an
// even-parity bit, and a parErr pulse is raised alongside rdValid whenever the
// stored parity does not match the data that is read back.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | accepting requests; clr starts a sweep
// CLEAR  | zeroing one word per cycle at r_cnt; requests and clr ignored
module word_memory_array #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wordIn,
  input  logic              clr,
  output logic [WIDTH-1:0]  wordOut,
  output logic              rdValid,
  output logic              busy,
  output logic              addrErr
`ifdef PARITY_EN
  ,
  output logic              parErr
`endif
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // Widened by one bit so that addr can be compared against DEPTH even when
  // DEPTH is an exact power of two.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  w_rd_data;
  logic              w_accept;
  logic              w_in_range;
  logic              w_sweep_done;

  // clr outranks sel in IDLE, and busy masks everything during CLEAR.
  assign w_accept     = sel & ~clr & (r_state == S_IDLE);
  assign w_in_range   = ({1'b0, addr} < DEPTH_X);
  assign w_sweep_done = (r_state == S_CLEAR) && (r_cnt == LAST_IDX);
  assign busy         = (r_state == S_CLEAR);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: the sweep is entered on clr and left after the last word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clr) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_sweep_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sweep counter: held at zero while idle and stepped once per CLEAR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_cnt <= '0;
    else if (r_state == S_CLEAR) r_cnt <= w_sweep_done ? '0 : r_cnt + 1'b1;
    else                         r_cnt <= '0;
  end

  // Word array: the sweep clears the word at r_cnt; otherwise an accepted,
  // in-range write updates the word it addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_state == S_CLEAR && r_cnt == ADDR_W'(i))
          r_mem[i] <= '0;
        else if (w_accept && !rw && w_in_range && addr == ADDR_W'(i))
          r_mem[i] <= wordIn;
      end
    end
  end

  // Read mux built as a decode, so out-of-range addresses never index past the array.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (addr == ADDR_W'(i)) w_rd_data = r_mem[i];
  end

  // Registered read port and address-error strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordOut <= '0;
      rdValid <= 1'b0;
      addrErr <= 1'b0;
    end else begin
      rdValid <= w_accept && rw && w_in_range;
      addrErr <= w_accept && !w_in_range;
      if (w_accept && rw && w_in_range) wordOut <= w_rd_data;
    end
  end

`ifdef PARITY_EN
  logic r_par [DEPTH];
  logic w_rd_par;

  // Parity array tracks the word array; cleared words carry parity 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_state == S_CLEAR && r_cnt == ADDR_W'(i))
          r_par[i] <= 1'b0;
        else if (w_accept && !rw && w_in_range && addr == ADDR_W'(i))
          r_par[i] <= ^wordIn;
      end
    end
  end

  // Stored parity bit for the addressed word.
  always_comb begin
    w_rd_par = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (addr == ADDR_W'(i)) w_rd_par = r_par[i];
  end

  // Parity mismatch strobe, aligned with rdValid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parErr <= 1'b0;
    else     parErr <= w_accept && rw && w_in_range && ((^w_rd_data) != w_rd_par);
  end
`endif

endmodule

// File: tb/tb_word_memory_array.sv
module tb_word_memory_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0, rw = 1'b0, clr = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] wordIn = '0;
  logic [7:0] wordOut;
  logic       rdValid, busy, addrErr;

  logic       s6_sel = 1'b0, s6_rw = 1'b0, s6_clr = 1'b0;
  logic [2:0] s6_addr = '0;
  logic [7:0] s6_wordIn = '0;
  logic [7:0] s6_wordOut;
  logic       s6_rdValid, s6_busy, s6_addrErr;
`ifdef PARITY_EN
  logic       parErr, s6_parErr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  word_memory_array #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .rw(rw), .addr(addr), .wordIn(wordIn),
    .clr(clr), .wordOut(wordOut), .rdValid(rdValid), .busy(busy), .addrErr(addrErr)
`ifdef PARITY_EN
    , .parErr(parErr)
`endif
  );

  word_memory_array #(.WIDTH(8), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .sel(s6_sel), .rw(s6_rw), .addr(s6_addr), .wordIn(s6_wordIn),
    .clr(s6_clr), .wordOut(s6_wordOut), .rdValid(s6_rdValid), .busy(s6_busy), .addrErr(s6_addrErr)
`ifdef PARITY_EN
    , .parErr(s6_parErr)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the DEPTH=8 instance: a plain array plus the number
  // of sweep cycles still to run.
  logic [7:0] m_mem [8];
  logic [7:0] m_out;
  logic       m_valid, m_err;
  int         m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      m_out = 8'h00; m_valid = 1'b0; m_err = 1'b0; m_left = 0;
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (m_left > 0) begin
        m_mem[8 - m_left] = 8'h00;
        m_left--;
      end else if (clr) begin
        m_left = 8;
      end else if (sel) begin
        if (rw) begin
          m_out   = m_mem[addr];
          m_valid = 1'b1;
        end else begin
          m_mem[addr] = wordIn;
        end
      end
    end
  end

  // Every cycle out of reset, compare the DEPTH=8 instance against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("wordOut", {24'd0, wordOut}, {24'd0, m_out});
      check("rdValid", {31'd0, rdValid}, {31'd0, m_valid});
      check("busy",    {31'd0, busy},    {31'd0, (m_left > 0)});
      check("addrErr", {31'd0, addrErr}, {31'd0, m_err});
`ifdef PARITY_EN
      check("parErr",  {31'd0, parErr},  32'd0);
`endif
    end
  end

  task automatic cyc(input logic s, input logic r, input logic [2:0] a,
                     input logic [7:0] d, input logic c);
    @(negedge clk);
    sel = s; rw = r; addr = a; wordIn = d; clr = c;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic cyc6(input logic s, input logic r, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    s6_sel = s; s6_rw = r; s6_addr = a; s6_wordIn = d;
  endtask

  int nb;
  int nvb;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset wordOut", {24'd0, wordOut}, 32'h00);
    check("reset busy",    {31'd0, busy},    32'd0);
    check("reset rdValid", {31'd0, rdValid}, 32'd0);
    check("reset addrErr", {31'd0, addrErr}, 32'd0);

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 3'(i), 8'h00, 1'b0);
    idle();

    cyc(1'b1, 1'b0, 3'd3, 8'hA5, 1'b0);
    cyc(1'b1, 1'b1, 3'd3, 8'h00, 1'b0);
    idle();
    check("raw data",  {24'd0, wordOut}, 32'hA5);
    check("raw valid", {31'd0, rdValid}, 32'd1);
    cyc(1'b1, 1'b1, 3'd4, 8'h00, 1'b0);
    idle();
    check("addr4 data", {24'd0, wordOut}, 32'h00);

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 3'(i), 8'(8'h10 + i), 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    nb = 0; nvb = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b1, 3'($urandom_range(0, 7)), 8'h00, 1'b0);
      if (busy) nb++;
      if (busy && rdValid) nvb++;
    end
    idle();
    check("busy cycles", nb, 32'd8);
    check("valid while busy", nvb, 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 3'(i), 8'h00, 1'b0);
    idle();

    cyc(1'b1, 1'b0, 3'd2, 8'hFF, 1'b1);
    repeat (9) idle();
    cyc(1'b1, 1'b1, 3'd2, 8'h00, 1'b0);
    idle();
    check("clr beats write", {24'd0, wordOut}, 32'h00);
    check("clr beats write valid", {31'd0, rdValid}, 32'd1);

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 3'(i), 8'h3C, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    repeat (4) idle();
    #2 rst = 1'b1;
    #1 check("busy on mid-sweep reset", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 3'(i), 8'h00, 1'b0);
    idle();
    check("post-reset last read", {24'd0, wordOut}, 32'h00);

    for (int k = 0; k < 400; k++)
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
          8'($urandom), ($urandom_range(0, 29) == 0));
    repeat (10) idle();

    cyc6(1'b1, 1'b0, 3'd3, 8'h77);
    cyc6(1'b1, 1'b1, 3'd3, 8'h00);
    cyc6(1'b0, 1'b0, 3'd0, 8'h00);
    check("d6 read3", {24'd0, s6_wordOut}, 32'h77);
    check("d6 read3 valid", {31'd0, s6_rdValid}, 32'd1);
    check("d6 read3 addrErr", {31'd0, s6_addrErr}, 32'd0);
    cyc6(1'b1, 1'b0, 3'd7, 8'hEE);
    cyc6(1'b0, 1'b0, 3'd0, 8'h00);
    check("d6 wr7 addrErr", {31'd0, s6_addrErr}, 32'd1);
    check("d6 wr7 valid", {31'd0, s6_rdValid}, 32'd0);
    cyc6(1'b1, 1'b1, 3'd6, 8'h00);
    cyc6(1'b0, 1'b0, 3'd0, 8'h00);
    check("d6 rd6 addrErr", {31'd0, s6_addrErr}, 32'd1);
    check("d6 rd6 valid", {31'd0, s6_rdValid}, 32'd0);
    check("d6 rd6 wordOut held", {24'd0, s6_wordOut}, 32'h77);
    cyc6(1'b0, 1'b0, 3'd0, 8'h00);
    check("d6 addrErr one cycle", {31'd0, s6_addrErr}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc6(1'b1, 1'b1, 3'(i), 8'h00);
      cyc6(1'b0, 1'b0, 3'd0, 8'h00);
      check("d6 array intact", {24'd0, s6_wordOut}, (i == 3) ? 32'h77 : 32'h00);
      check("d6 array valid", {31'd0, s6_rdValid}, 32'd1);
`ifdef PARITY_EN
      check("d6 parErr", {31'd0, s6_parErr}, 32'd0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/word_memory_array.md
Name: word_memory_array

Overview:
- Parametrised successor to the fixed 8x8 bit-cell word store: a synchronous WIDTH x DEPTH word memory with an addressed read/write port.
- Adds a registered read path with a valid strobe, plus a sequenced bulk-clear engine with a busy indication.
- Sits where the per-word bit-cell stacks sat; serves as the storage core of the memory IC.

Parameters:
- WIDTH, 8, bits per word (>=1).
- DEPTH, 8, number of words (>=2).
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sel  input  1  request strobe; one access per cycle where sel=1 and busy=0.
- rw  input  1  access type: 1 = read, 0 = write.
- addr  input  ADDR_W  word address.
- wordIn  input  WIDTH  write data.
- clr  input  1  bulk-clear request, single-cycle pulse.
- wordOut  output  WIDTH  registered read data.
- rdValid  output  1  one-cycle pulse; wordOut valid for this read.
- busy  output  1  high while the clear sweep runs; requests are ignored.
- addrErr  output  1  one-cycle pulse when an accepted request has addr >= DEPTH.

Behaviour:
- Reset (async assert, sync-safe deassert), applied immediately:
  - all DEPTH words = 0
  - wordOut = 0, rdValid = 0, busy = 0, addrErr = 0
  - FSM = IDLE, sweep counter = 0.
- Acceptance: a request is accepted on a rising edge when sel=1, busy=0, clr=0, and FSM = IDLE.
- Write (rw=0): mem[addr] <= wordIn at the accepting edge. wordOut and rdValid are unchanged/0.
- Read (rw=1), latency 1:
  - wordOut <= mem[addr] at the accepting edge; rdValid=1 for the following cycle only.
  - wordOut holds its value until the next accepted read.
- Read-after-write to the same address on the next cycle returns the new data. There is no same-cycle bypass; only one access per cycle is possible.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH is not a power of two):
  - a write is dropped; a read leaves wordOut unchanged and rdValid=0
  - addrErr pulses for 1 cycle.
- FSM states and transitions:
  - IDLE: clr=1 -> CLEAR, with busy=1 from the next cycle and counter=0. clr has priority over a same-cycle sel; that request is dropped with no rdValid and no write.
  - CLEAR: mem[counter] <= 0, counter++ each cycle. When counter = DEPTH-1 is written -> IDLE; busy falls the cycle after the last word is cleared. The sweep takes exactly DEPTH cycles with busy=1.
  - While in CLEAR, sel and clr are ignored; there is no queuing and no restart.
- Reset asserted mid-sweep: the FSM immediately returns to IDLE and the array is fully zeroed by reset.
- No X-propagation: wordOut is never X after reset.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - each word stores an extra even-parity bit computed from wordIn on write; clear and reset store parity 0.
  - on a read, the stored parity is checked; output parErr (1 bit, registered) pulses together with rdValid on a mismatch.
  - the port exists only when the macro is defined.
- Undefined: no parity storage, no parErr port; all other behaviour is identical.

Test Plan:
- Reset, then read all addresses 0..7 -> wordOut=0x00 with rdValid high one cycle after each request.
- Write 0xA5 to addr 3, read addr 3 next cycle -> rdValid pulse, wordOut=0xA5; read addr 4 -> 0x00.
- Fill addr 0..7 with 0x10+i, pulse clr -> busy high exactly 8 cycles; reads during busy give no rdValid; after busy falls all reads return 0x00.
- clr and sel (write 0xFF to addr 2) in the same cycle -> write dropped, sweep runs; addr 2 reads 0x00 afterwards.
- Assert rst at sweep cycle 4 after writing 0x3C everywhere -> busy=0 immediately; all words read 0x00.
- DEPTH=6: write to addr 7 -> addrErr pulse and no array change; read addr 6 -> addrErr pulse, rdValid=0, wordOut unchanged. With PARITY_EN, force a stored-bit flip on addr 1 and read it -> parErr=1 with rdValid.
